// File: rtl/mul_issue_ctrl.sv
// Issue controller for the 2-stage unsigned multiplier: credit-gated issue, signed
// high-word correction carried alongside the product, and an in-order result FIFO.
module mul_issue_ctrl #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_s,
  input  logic [31:0]      mul_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + LAT + 1);

  // Unsigned high word minus this term gives the signed high word, mod 2^32.
  function automatic logic [31:0] corr_term(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] ta;
    logic [31:0] tb;
    ta = a[31] ? b : 32'd0;
    tb = b[31] ? a : 32'd0;
    case (op)
      2'b01:   corr_term = ta + tb;
      2'b10:   corr_term = ta;
      default: corr_term = 32'd0;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic             fire;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LAT-1:0]   vld_q;
  logic [TAG_W-1:0] tag_q  [LAT];
  logic [31:0]      corr_q [LAT];
  logic [31:0]      data_q [DEPTH];
  logic [TAG_W-1:0] ftag_q [DEPTH];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CNT_W'(vld_q[i]);
  end

  // The multiplier cannot stall, so every accepted op must already own a FIFO slot.
  assign in_ready = !flush && ((inflight + count_q) < CNT_W'(DEPTH));
  assign fire     = in_valid & in_ready;
  assign mul_a    = fire ? in_rs1 : 32'd0;
  assign mul_b    = fire ? in_rs2 : 32'd0;
  assign mul_s    = fire & (in_op != 2'b00);
  assign push     = vld_q[LAT-1];
  assign pop      = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= fire;
      for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_q[0]  <= in_tag;
    corr_q[0] <= corr_term(in_op, in_rs1, in_rs2);
    for (int i = 1; i < LAT; i++) begin
      tag_q[i]  <= tag_q[i-1];
      corr_q[i] <= corr_q[i-1];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        ftag_q[i] <= '0;
      end
    end else if (push && !flush) begin
      data_q[wr_ptr_q] <= mul_o - corr_q[LAT-1];
      ftag_q[wr_ptr_q] <= tag_q[LAT-1];
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = data_q[rd_ptr_q];
  assign out_tag   = ftag_q[rd_ptr_q];
  assign busy      = (inflight != '0) | out_valid;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: models the external 2-stage unsigned multiplier and
// scores every result against a full-width signed/unsigned reference product.
module tb_mul_issue_ctrl;
  localparam int TAG_W = 5;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [1:0]       in_op = 2'b00;
  logic [31:0]      in_rs1 = '0;
  logic [31:0]      in_rs2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_ready, mul_s, out_valid, busy;
  logic [31:0]      mul_a, mul_b, mul_o, out_data;
  logic [TAG_W-1:0] out_tag;

  mul_issue_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s), .mul_o(mul_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // External multiplier: unsigned, two register stages, half select applied at issue.
  logic [63:0] full;
  logic [31:0] m1_q, m2_q;
  assign full = {32'd0, mul_a} * {32'd0, mul_b};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m1_q <= '0;
      m2_q <= '0;
    end else begin
      m1_q <= mul_s ? full[63:32] : full[31:0];
      m2_q <= m1_q;
    end
  end
  assign mul_o = m2_q;

  typedef struct packed {
    logic [31:0]      d;
    logic [TAG_W-1:0] t;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   npop = 0;
  int   max_out = 0;
  logic last_fire = 1'b0;
  logic toggle_rdy = 1'b0;

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sbb, ua, ub, p;
    sa  = {{32{a[31]}}, a};
    sbb = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      2'b01:   p = sa * sbb;
      2'b10:   p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // One clock: scoreboard pop/compare, then push of any accepted request.
  task automatic tick();
    exp_t e;
    if (toggle_rdy) out_ready = ~out_ready;
    #1;
    last_fire = in_valid && in_ready;
    if (out_valid && out_ready) begin
      npop++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got data %h tag %0d, required no result", out_data, out_tag);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.d || out_tag !== e.t) begin
          fails++;
          $display("FAIL sb_result: got data %h tag %0d, required data %h tag %0d",
                   out_data, out_tag, e.d, e.t);
        end
      end
    end
    if (last_fire) begin
      e.d = ref_mul(in_op, in_rs1, in_rs2);
      e.t = in_tag;
      sb.push_back(e);
    end
    if (sb.size() > max_out) max_out = sb.size();
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t);
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = t;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (last_fire) break;
    end
    if (!last_fire) begin
      tests++; fails++;
      $display("FAIL send_timeout: tag %0d not accepted in 40 cycles, required accept", t);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (sb.size() == 0 && !busy) break;
      tick();
    end
    tests++;
    if (sb.size() != 0 || busy) begin
      fails++;
      $display("FAIL drain: got %0d outstanding busy %b, required 0 and 0", sb.size(), busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    tests += 6;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    if (out_data !== 32'd0) begin fails++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
    if (out_tag !== '0) begin fails++; $display("FAIL rst_out_tag: got %0d, required 0", out_tag); end
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    if (mul_a !== 32'd0 || mul_b !== 32'd0 || mul_s !== 1'b0) begin
      fails++; $display("FAIL rst_mul: got a %h b %h s %b, required zeros", mul_a, mul_b, mul_s);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_basic();
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'd7; in_rs2 = 32'd6; in_tag = TAG_W'(3);
    #1;
    tests += 2;
    if (in_ready !== 1'b1 || mul_s !== 1'b0) begin
      fails++; $display("FAIL basic_issue: got ready %b mul_s %b, required 1 and 0", in_ready, mul_s);
    end
    if (mul_a !== 32'd7 || mul_b !== 32'd6) begin
      fails++; $display("FAIL basic_operands: got %h %h, required 7 6", mul_a, mul_b);
    end
    tick();
    in_valid = 1'b0;
    #1;
    tests += 2;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_c1: got out_valid %b, required 0", out_valid); end
    if (mul_a !== 32'd0 || mul_s !== 1'b0) begin
      fails++; $display("FAIL basic_idle_mul: got a %h s %b, required 0 0", mul_a, mul_s);
    end
    tick();
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_c2: got out_valid %b, required 0", out_valid); end
    tick();
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'd42 || out_tag !== TAG_W'(3)) begin
      fails++; $display("FAIL basic_c3: got valid %b data %h tag %0d, required 1 42 3",
                        out_valid, out_data, out_tag);
    end
    tick();
    drain();
  endtask

  task automatic test_ops();
    int p0;
    p0 = npop;
    out_ready = 1'b1;
    send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, TAG_W'(1));
    send(2'b10, 32'hFFFF_FFFF, 32'd2, TAG_W'(2));
    send(2'b11, 32'h8000_0000, 32'd4, TAG_W'(3));
    send(2'b01, 32'h8000_0000, 32'h8000_0000, TAG_W'(4));
    for (int i = 0; i < 8; i++) send(2'(i), $urandom, $urandom, TAG_W'(i + 5));
    drain();
    tests++;
    if (npop - p0 != 12) begin fails++; $display("FAIL ops_count: got %0d results, required 12", npop - p0); end
  endtask

  task automatic test_back_to_back();
    int p0, c0;
    p0 = npop;
    out_ready = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 4; i++) send(2'(i), $urandom, $urandom, TAG_W'(10 + i));
    tests++;
    if (cyc - c0 != 4) begin fails++; $display("FAIL b2b_accept: got %0d cycles for 4 accepts, required 4", cyc - c0); end
    in_valid = 1'b1; in_op = 2'b01; in_rs1 = $urandom; in_rs2 = $urandom; in_tag = TAG_W'(14);
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_credit: got in_ready %b, required 0", in_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_pop_cycle: got in_ready %b, required 0", in_ready); end
    tick();
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_after_pop: got in_ready %b, required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    send(2'b10, $urandom, $urandom, TAG_W'(15));
    drain();
    tests++;
    if (npop - p0 != 6) begin fails++; $display("FAIL b2b_count: got %0d results, required 6", npop - p0); end
  endtask

  task automatic test_wrap();
    int p0;
    p0 = npop;
    max_out = 0;
    out_ready = 1'b0;
    toggle_rdy = 1'b1;
    for (int i = 0; i < 10; i++) send(2'(i), $urandom, $urandom, TAG_W'(16 + i));
    toggle_rdy = 1'b0;
    drain();
    tests += 2;
    if (npop - p0 != 10) begin fails++; $display("FAIL wrap_count: got %0d results, required 10", npop - p0); end
    if (max_out != DEPTH) begin fails++; $display("FAIL wrap_outstanding: got max %0d, required %0d", max_out, DEPTH); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(2'b00, 32'd5, 32'd5, TAG_W'(1));
    send(2'b01, 32'hFFFF_FFF0, 32'd3, TAG_W'(2));
    send(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, TAG_W'(3));
    flush = 1'b1;
    #1;
    tests += 2;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b, required 0", in_ready); end
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL flush_pre: got valid %b busy %b, required 1 1", out_valid, busy);
    end
    tick();
    flush = 1'b0;
    sb.delete();
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL flush_post: got valid %b busy %b, required 0 0", out_valid, busy);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_stale: got out_valid %b, required 0", out_valid); end
      tick();
    end
    in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'd3; in_rs2 = 32'd3; in_tag = TAG_W'(7);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'd9 || out_tag !== TAG_W'(7)) begin
      fails++; $display("FAIL flush_new: got valid %b data %h tag %0d, required 1 9 7",
                        out_valid, out_data, out_tag);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(2'b00, 32'd11, 32'd13, TAG_W'(4));
    send(2'b01, 32'h8000_0001, 32'd7, TAG_W'(5));
    send(2'b10, 32'hF000_0000, 32'd9, TAG_W'(6));
    #2 reset = 1'b1;
    #1;
    tests += 3;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rmid_valid: got valid %b busy %b, required 0 0", out_valid, busy);
    end
    if (out_data !== 32'd0 || out_tag !== '0) begin
      fails++; $display("FAIL rmid_data: got data %h tag %0d, required 0 0", out_data, out_tag);
    end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready: got %b, required 1", in_ready); end
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL rmid_stale: got valid %b busy %b, required 0 0", out_valid, busy);
      end
      tick();
    end
    send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, TAG_W'(9));
    tick();
    tick();
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFE || out_tag !== TAG_W'(9)) begin
      fails++; $display("FAIL rmid_fresh: got valid %b data %h tag %0d, required 1 fffffffe 9",
                        out_valid, out_data, out_tag);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_ops();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
